// File: rtl/std_fifo_rd_arbiter.sv
// -----------------------------------------------------------------------------
// std_fifo_rd_arbiter
//
// Shares the read port of one standard-mode (non-FWFT) FIFO between
// NUM_PORTS requesters. A round-robin arbiter issues at most one FIFO read per
// cycle. A tag pipeline as deep as the FIFO read latency records which
// requester won each read. When the word comes back, it is steered to that
// requester.
//
// Ports:
//   clk                  rising-edge clock
//   arst                 asynchronous active-high reset
//   port_req[N]          level request per requester (one word per granted cycle)
//   port_gnt[N]          one-hot/zero grant, combinational, same cycle as request
//   port_dout[W]         shared return data (FIFO dout passed straight through)
//   port_dout_valid[N]   one-hot/zero owner of port_dout this cycle
//   standard_fifo_dout   FIFO read data
//   standard_fifo_empty  FIFO empty flag
//   standard_fifo_rd_en  FIFO read enable (OR of port_gnt)
// -----------------------------------------------------------------------------
module std_fifo_rd_arbiter #(
    parameter int NUM_PORTS                  = 2,
    parameter int STANDARD_FIFO_READ_LATENCY = 1,
    parameter int STANDARD_FIFO_DOUT_WIDTH   = 8
) (
    input  logic                                clk,
    input  logic                                arst,
    input  logic [NUM_PORTS-1:0]                port_req,
    output logic [NUM_PORTS-1:0]                port_gnt,
    output logic [STANDARD_FIFO_DOUT_WIDTH-1:0] port_dout,
    output logic [NUM_PORTS-1:0]                port_dout_valid,
    input  logic [STANDARD_FIFO_DOUT_WIDTH-1:0] standard_fifo_dout,
    input  logic                                standard_fifo_empty,
    output logic                                standard_fifo_rd_en
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LAT   = STANDARD_FIFO_READ_LATENCY;
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

    logic [PTR_W-1:0]     rr_ptr;
    logic                 pick_vld;
    logic [PTR_W-1:0]     pick_idx;
    logic [NUM_PORTS-1:0] tag_p [LAT];

    // Round-robin search starting at ptr. The loop runs from the farthest
    // candidate back to ptr itself. As a result, the nearest requester in
    // search order is the last one written and wins.
    // Returns {found, index}.
    function automatic logic [PTR_W:0] rr_pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [PTR_W-1:0]     ptr
    );
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] pidx;
        int               idx;
        res = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx  = (int'(ptr) + i) % NUM_PORTS;
            pidx = idx[PTR_W-1:0];
            if (req[pidx]) begin
                res = {1'b1, pidx};
            end
        end
        return res;
    endfunction

    // Stage p0: combinational grant. Nothing is issued while the FIFO is
    // empty or while reset is high. Gating on arst means that a read never
    // starts in the cycle reset rises, so no data can appear later for it.
    always_comb begin
        {pick_vld, pick_idx} = rr_pick(port_req, rr_ptr);
        port_gnt = '0;
        if (pick_vld && !standard_fifo_empty && !arst) begin
            port_gnt = NUM_PORTS'(1) << pick_idx;
        end
    end

    assign standard_fifo_rd_en = |port_gnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rr_ptr <= '0;
        end else if (standard_fifo_rd_en) begin
            rr_ptr <= (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
        end
    end

    // Stages p1..pLAT: the grant tags follow the read through the FIFO
    // latency. The last stage lines up with valid FIFO dout.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int j = 0; j < LAT; j++) begin
                tag_p[j] <= '0;
            end
        end else begin
            tag_p[0] <= port_gnt;
            for (int j = 1; j < LAT; j++) begin
                tag_p[j] <= tag_p[j-1];
            end
        end
    end

    assign port_dout_valid = tag_p[LAT-1];
    assign port_dout       = standard_fifo_dout;

endmodule

// File: tb/tb_std_fifo_rd_arbiter.sv
module tb_std_fifo_rd_arbiter;

    localparam int NDUT = 4;
    localparam int NP [NDUT] = '{2, 2, 2, 4};
    localparam int LT [NDUT] = '{1, 3, 2, 1};
    localparam int DW = 8;

    typedef struct {
        logic [3:0]    vld;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk  = 1'b0;
    logic          arst = 1'b1;
    logic [3:0]    req_r     [NDUT];
    logic [3:0]    gnt_w     [NDUT];
    logic [3:0]    vld_w     [NDUT];
    logic          rd_w      [NDUT];
    logic [DW-1:0] dout_w    [NDUT];
    logic          empty_r   [NDUT];
    logic [DW-1:0] dly       [NDUT][4];
    logic [DW-1:0] fifo_dout [NDUT];
    logic [DW-1:0] fifo_q    [NDUT][$];
    exp_t          exp_q[$];

    int sel       = 0;
    int cyc       = 0;
    int n_chk     = 0;
    int n_err     = 0;
    int underflow = 0;
    int rx_cnt [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [NP[g]-1:0] req_l;
        logic [NP[g]-1:0] gnt_l;
        logic [NP[g]-1:0] vld_l;
        logic             rd_l;
        logic [DW-1:0]    dout_l;

        assign req_l        = req_r[g][NP[g]-1:0];
        assign gnt_w[g]     = 4'(gnt_l);
        assign vld_w[g]     = 4'(vld_l);
        assign rd_w[g]      = rd_l;
        assign dout_w[g]    = dout_l;
        assign fifo_dout[g] = dly[g][LT[g]-1];

        std_fifo_rd_arbiter #(
            .NUM_PORTS                 (NP[g]),
            .STANDARD_FIFO_READ_LATENCY(LT[g]),
            .STANDARD_FIFO_DOUT_WIDTH  (DW)
        ) u_dut (
            .clk                (clk),
            .arst               (arst),
            .port_req           (req_l),
            .port_gnt           (gnt_l),
            .port_dout          (dout_l),
            .port_dout_valid    (vld_l),
            .standard_fifo_dout (fifo_dout[g]),
            .standard_fifo_empty(empty_r[g]),
            .standard_fifo_rd_en(rd_l)
        );
    end

    // Standard-mode FIFO model: the data appears LT cycles after rd_en, and
    // empty updates on the edge after the read.
    always @(posedge clk or posedge arst) begin
        for (int g = 0; g < NDUT; g++) begin
            if (arst) begin
                fifo_q[g].delete();
                empty_r[g] <= 1'b1;
            end else begin
                for (int k = 3; k > 0; k--) dly[g][k] <= dly[g][k-1];
                if (rd_w[g]) begin
                    if (fifo_q[g].size() == 0) underflow <= underflow + 1;
                    else dly[g][0] <= fifo_q[g].pop_front();
                end
                empty_r[g] <= (fifo_q[g].size() == 0);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard drain: each expected word is compared in its due cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!arst) begin
            if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("dout_valid", 32'(vld_w[sel]), 32'(e.vld));
                chk("dout_data", 32'(dout_w[sel]), 32'(e.data));
            end else if (vld_w[sel] != 4'd0) begin
                chk("spurious_valid", 32'(vld_w[sel]), 32'd0);
            end
            for (int p = 0; p < 4; p++) if (vld_w[sel][p]) rx_cnt[p]++;
        end
    end

    task automatic fifo_push(input logic [DW-1:0] d);
        fifo_q[sel].push_back(d);
    endtask

    // One cycle: drive req, optionally enqueue the expected return, check grant.
    task automatic step(input string tag, input logic [3:0] req, input logic [3:0] gnt_exp,
                        input logic [DW-1:0] data, input bit deliver);
        exp_t e;
        @(negedge clk); #1;
        req_r[sel] = req;
        if (gnt_exp != 4'd0 && deliver) begin
            e.vld  = gnt_exp;
            e.data = data;
            e.due  = cyc + LT[sel];
            exp_q.push_back(e);
        end
        #1;
        chk(tag, 32'(gnt_w[sel]), 32'(gnt_exp));
        chk({tag, "_rd_en"}, 32'(rd_w[sel]), 32'(gnt_exp != 4'd0));
    endtask

    task automatic drain(input string tag, input int n);
        repeat (n) begin
            @(negedge clk); #1;
            req_r[sel] = 4'd0;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        arst = 1'b1;
        req_r[sel] = 4'hF;
        #1;
        chk("rst_gnt", 32'(gnt_w[sel]), 32'd0);
        chk("rst_rd_en", 32'(rd_w[sel]), 32'd0);
        chk("rst_valid", 32'(vld_w[sel]), 32'd0);
        @(negedge clk); #1;
        arst = 1'b0;
        req_r[sel] = 4'd0;
        exp_q.delete();
        for (int p = 0; p < 4; p++) rx_cnt[p] = 0;
    endtask

    initial begin
        for (int g = 0; g < NDUT; g++) req_r[g] = 4'd0;
        for (int p = 0; p < 4; p++) rx_cnt[p] = 0;

        // Two ports, latency 1, alternating grants until empty
        sel = 0;
        do_reset();
        fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33); fifo_push(8'h44);
        step("t1_gnt0", 4'b11, 4'b01, 8'h11, 1'b1);
        step("t1_gnt1", 4'b11, 4'b10, 8'h22, 1'b1);
        step("t1_gnt2", 4'b11, 4'b01, 8'h33, 1'b1);
        step("t1_gnt3", 4'b11, 4'b10, 8'h44, 1'b1);
        step("t1_empty", 4'b11, 4'b00, 8'h00, 1'b0);
        drain("t1_drain", 3);

        // Only port 1 requests, latency 3; pointer then wraps to port 0
        sel = 1;
        do_reset();
        fifo_push(8'hA1); fifo_push(8'hB2); fifo_push(8'hC3);
        step("t2_gnt0", 4'b10, 4'b10, 8'hA1, 1'b1);
        step("t2_gnt1", 4'b10, 4'b10, 8'hB2, 1'b1);
        step("t2_gnt2", 4'b10, 4'b10, 8'hC3, 1'b1);
        step("t2_empty", 4'b10, 4'b00, 8'h00, 1'b0);
        drain("t2_drain", 5);
        fifo_push(8'hD4);
        step("t2_ptr0", 4'b11, 4'b01, 8'hD4, 1'b1);
        drain("t2_drain2", 5);

        // Empty FIFO blocks all grants; a single write then goes to port 0
        sel = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step("t3_empty_gnt", 4'b11, 4'b00, 8'h00, 1'b0);
            chk("t3_empty_valid", 32'(vld_w[sel]), 32'd0);
        end
        fifo_push(8'h5A);
        step("t3_gnt", 4'b11, 4'b01, 8'h5A, 1'b1);
        step("t3_after", 4'b11, 4'b00, 8'h00, 1'b0);
        drain("t3_drain", 3);

        // Four ports, all requesting, eight words
        sel = 3;
        do_reset();
        for (int i = 0; i < 8; i++) fifo_push(8'(8'h80 + i));
        for (int i = 0; i < 8; i++)
            step("t4_gnt", 4'hF, 4'(1 << (i % 4)), 8'(8'h80 + i), 1'b1);
        step("t4_empty", 4'hF, 4'd0, 8'h00, 1'b0);
        drain("t4_drain", 3);
        for (int p = 0; p < 4; p++) chk("t4_per_port", 32'(rx_cnt[p]), 32'd2);

        // Reset with reads in flight, latency 2
        sel = 2;
        do_reset();
        fifo_push(8'hE1); fifo_push(8'hE2); fifo_push(8'hE3); fifo_push(8'hE4);
        step("t5_gnt0", 4'b01, 4'b01, 8'hE1, 1'b0);
        step("t5_gnt1", 4'b01, 4'b01, 8'hE2, 1'b0);
        #1 arst = 1'b1;
        @(negedge clk); #1;
        chk("t5_rst_gnt", 32'(gnt_w[sel]), 32'd0);
        chk("t5_rst_valid", 32'(vld_w[sel]), 32'd0);
        @(negedge clk); #1;
        arst = 1'b0;
        req_r[sel] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step("t5_post_gnt", 4'b00, 4'b00, 8'h00, 1'b0);
            chk("t5_post_valid", 32'(vld_w[sel]), 32'd0);
        end
        fifo_push(8'h66);
        step("t5_first", 4'b11, 4'b01, 8'h66, 1'b1);
        drain("t5_drain", 4);

        // Port 0 drops req after its grant; its word still arrives
        sel = 2;
        do_reset();
        fifo_push(8'h71); fifo_push(8'h72);
        step("t6_gnt0", 4'b11, 4'b01, 8'h71, 1'b1);
        step("t6_gnt1", 4'b10, 4'b10, 8'h72, 1'b1);
        step("t6_idle", 4'b00, 4'b00, 8'h00, 1'b0);
        drain("t6_drain", 4);

        chk("fifo_underflow", 32'(underflow), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
